// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator.
// Holds the default 640x480@60 timing, the derived line/frame totals, the
// coordinate type used for DrawX/DrawY, and the colors and bar lookup used by
// the optional built-in test pattern.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Default 640x480@60 timing (25 MHz pixel clock)
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

  // Test-pattern colors, {r,g,b} with 4 bits per component
  localparam logic [11:0] TP_WHITE   = 12'hFFF;
  localparam logic [11:0] TP_YELLOW  = 12'hFF0;
  localparam logic [11:0] TP_CYAN    = 12'h0FF;
  localparam logic [11:0] TP_GREEN   = 12'h0F0;
  localparam logic [11:0] TP_MAGENTA = 12'hF0F;
  localparam logic [11:0] TP_RED     = 12'hF00;
  localparam logic [11:0] TP_BLUE    = 12'h00F;
  localparam logic [11:0] TP_BLACK   = 12'h000;

  // Color of vertical bar idx (0 = leftmost); anything past the last bar is black
  function automatic logic [11:0] tp_bar_color(input int idx);
    case (idx)
      0:       return TP_WHITE;
      1:       return TP_YELLOW;
      2:       return TP_CYAN;
      3:       return TP_GREEN;
      4:       return TP_MAGENTA;
      5:       return TP_RED;
      6:       return TP_BLUE;
      default: return TP_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Parametric-depth shift register used to delay sync (and test-pattern) signals
// so they line up with the renderer's registered RGB.
// Ports:
//   vga_clk - pixel clock
//   reset   - asynchronous reset, active-high; fills every stage with RESET_VAL
//   din     - value entering the delay line
//   dout    - din delayed by DEPTH cycles (DEPTH = 0 is a straight wire)
module vga_sync_delay #(
  parameter int               DEPTH     = 1,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: this small array is reset on purpose -- its contents drive the sync
    // pins directly, so it must hold the inactive level, never X, after reset.
    always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 640x480@60 display pipeline.
// DrawX/DrawY/blank feed the sprite renderers, which register RGB one clock
// later; hs/vs are delayed by PIPE_DELAY to line up with that RGB. frame_start,
// vblank_start and frame_count serve the game-state logic.
// Every output is registered and computed from the next-state counters, so all
// of them change on the same edge as DrawX/DrawY.
// Ports:
//   vga_clk      - pixel clock, 25 MHz
//   reset        - asynchronous reset, active-high
//   DrawX/DrawY  - horizontal / vertical counters
//   blank        - 1 in the visible region (display enable), 0 when blanked
//   hs/vs        - sync, active level SYNC_POL, lagging DrawX/DrawY by PIPE_DELAY
//   frame_start  - one-cycle pulse at (0,0) (not for the reset frame)
//   vblank_start - one-cycle pulse at (0,V_VISIBLE)
//   frame_count  - completed-frame counter, wraps modulo 2^FRAME_CNT_W
//   tp_rgb       - colour-bar test pattern, only with VGA_TIMING_TEST_PATTERN_EN
// Build option: define VGA_TIMING_TEST_PATTERN_EN to add tp_rgb.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE   = H_VISIBLE_DEF,
  parameter int   H_FP        = H_FP_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BP        = H_BP_DEF,
  parameter int   V_VISIBLE   = V_VISIBLE_DEF,
  parameter int   V_FP        = V_FP_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BP        = V_BP_DEF,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   PIPE_DELAY  = 1,
  parameter int   FRAME_CNT_W = 16
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  output logic [9:0]             DrawX,
  output logic [9:0]             DrawY,
  output logic                   blank,
  output logic                   hs,
  output logic                   vs,
  output logic                   frame_start,
  output logic                   vblank_start,
  output logic [FRAME_CNT_W-1:0] frame_count
`ifdef VGA_TIMING_TEST_PATTERN_EN
  ,
  output logic [11:0]            tp_rgb
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds the 10-bit coordinate range");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds the 10-bit coordinate range");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
    $error("vga_timing_gen: PIPE_DELAY must be 0..4");
  end

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS      = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS      = coord_t'(V_VISIBLE);
  localparam coord_t HS_FIRST   = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_LAST    = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST   = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_LAST    = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic   SYNC_ON    = SYNC_POL;
  localparam logic   SYNC_OFF   = ~SYNC_POL;

  coord_t hc, vc;
  coord_t hc_n, vc_n;
  logic   vis_n;
  logic   hs_raw, vs_raw;

  // Next-state counters; everything registered below is derived from these so
  // it lands on the same edge as the counters themselves.
  // NOTE: every signal written here gets its default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    hc_n = hc + 1'b1;
    vc_n = vc;
    if (hc == H_LAST) begin
      hc_n = '0;
      vc_n = (vc == V_LAST) ? coord_t'(0) : vc + 1'b1;
    end
  end

  assign vis_n = (hc_n < H_VIS) && (vc_n < V_VIS);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others regardless of order.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc           <= '0;
      vc           <= '0;
      blank        <= 1'b0;
      hs_raw       <= SYNC_OFF;
      vs_raw       <= SYNC_OFF;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_count  <= '0;
    end else begin
      hc           <= hc_n;
      vc           <= vc_n;
      blank        <= vis_n;
      hs_raw       <= (hc_n >= HS_FIRST && hc_n <= HS_LAST) ? SYNC_ON : SYNC_OFF;
      vs_raw       <= (vc_n >= VS_FIRST && vc_n <= VS_LAST) ? SYNC_ON : SYNC_OFF;
      frame_start  <= (hc_n == '0) && (vc_n == '0);
      vblank_start <= (hc_n == '0) && (vc_n == V_VIS);
      if ((hc_n == '0) && (vc_n == '0)) frame_count <= frame_count + 1'b1;
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  // hs_raw/vs_raw are aligned with DrawX/DrawY; delay them to match the
  // renderer's RGB register.
  vga_sync_delay #(
    .DEPTH     (PIPE_DELAY),
    .WIDTH     (2),
    .RESET_VAL ({SYNC_OFF, SYNC_OFF})
  ) u_sync_delay (
    .vga_clk (vga_clk),
    .reset   (reset),
    .din     ({hs_raw, vs_raw}),
    .dout    ({hs, vs})
  );

`ifdef VGA_TIMING_TEST_PATTERN_EN
  // Eight vertical colour bars, registered alongside blank, then delayed with
  // it so the pattern lines up with hs/vs.
  int          tp_bar;
  logic [11:0] tp_raw;
  logic [11:0] tp_d;
  logic        tp_blank_d;

  assign tp_bar = int'(hc_n) / (H_VISIBLE / 8);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      tp_raw <= '0;
    end else begin
      tp_raw <= vis_n ? tp_bar_color(tp_bar) : TP_BLACK;
    end
  end

  vga_sync_delay #(
    .DEPTH     (PIPE_DELAY),
    .WIDTH     (13),
    .RESET_VAL (13'h0)
  ) u_tp_delay (
    .vga_clk (vga_clk),
    .reset   (reset),
    .din     ({blank, tp_raw}),
    .dout    ({tp_blank_d, tp_d})
  );

  assign tp_rgb = tp_blank_d ? tp_d : TP_BLACK;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Instance u_dut_a uses the default 640x480 timing
// (SYNC_POL=0, PIPE_DELAY=1); instance u_dut_b uses a tiny 16x10 raster with
// SYNC_POL=1, PIPE_DELAY=2 and a 4-bit frame counter so many frames fit in a
// short run. Expected values come from closed-form raster arithmetic on the
// cycle index since reset release.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  logic rst_a, rst_b;

  logic [9:0]  a_x, a_y;
  logic        a_blank, a_hs, a_vs, a_fs, a_vbs;
  logic [15:0] a_fc;

  logic [9:0]  b_x, b_y;
  logic        b_blank, b_hs, b_vs, b_fs, b_vbs;
  logic [3:0]  b_fc;

`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [11:0] a_tp, b_tp;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  vga_timing_gen u_dut_a (
    .vga_clk      (vga_clk),
    .reset        (rst_a),
    .DrawX        (a_x),
    .DrawY        (a_y),
    .blank        (a_blank),
    .hs           (a_hs),
    .vs           (a_vs),
    .frame_start  (a_fs),
    .vblank_start (a_vbs),
    .frame_count  (a_fc)
`ifdef VGA_TIMING_TEST_PATTERN_EN
    ,
    .tp_rgb       (a_tp)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_VISIBLE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .SYNC_POL (1'b1), .PIPE_DELAY (2), .FRAME_CNT_W (4)
  ) u_dut_b (
    .vga_clk      (vga_clk),
    .reset        (rst_b),
    .DrawX        (b_x),
    .DrawY        (b_y),
    .blank        (b_blank),
    .hs           (b_hs),
    .vs           (b_vs),
    .frame_start  (b_fs),
    .vblank_start (b_vbs),
    .frame_count  (b_fc)
`ifdef VGA_TIMING_TEST_PATTERN_EN
    ,
    .tp_rgb       (b_tp)
`endif
  );

  // Both DUTs held in reset: every output at its reset value.
  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge vga_clk);
    chk_cnt++;
    if ({a_x, a_y, a_blank, a_hs, a_vs, a_fs, a_vbs} !==
        {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_a_outputs: x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b vbs=%b, want 0 0 0 1 1 0 0",
               a_x, a_y, a_blank, a_hs, a_vs, a_fs, a_vbs);
    else pass_cnt++;
    chk_cnt++;
    if (a_fc !== 16'd0) $display("FAIL reset_a_frame_count: got %0d want 0", a_fc);
    else pass_cnt++;
    chk_cnt++;
    if ({b_x, b_y, b_blank, b_hs, b_vs, b_fs, b_vbs, b_fc} !==
        {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0})
      $display("FAIL reset_b_outputs: x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b vbs=%b fc=%0d, want all 0",
               b_x, b_y, b_blank, b_hs, b_vs, b_fs, b_vbs, b_fc);
    else pass_cnt++;
  endtask

  // Default timing: first edge after release, two full lines, hsync placement.
  task automatic test_line_timing();
    int coord_err, blank_err, hs_err, misc_err, tp_err;
    int first_bad, blank_line1, hs_low_line0, hs_first;
    int ex, ey, px;
    logic eb, eh;
    logic [11:0] bars [8];
    logic [11:0] etp;
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    coord_err = 0; blank_err = 0; hs_err = 0; misc_err = 0; tp_err = 0;
    first_bad = -1; blank_line1 = 0; hs_low_line0 = 0; hs_first = -1;
    rst_a = 1'b0;
    for (int k = 1; k <= 1700; k++) begin
      @(negedge vga_clk);
      if (k == 1) begin
        chk_cnt++;
        if ({a_x, a_y, a_blank} !== {10'd1, 10'd0, 1'b1})
          $display("FAIL first_edge: x=%0d y=%0d blank=%b, want 1 0 1", a_x, a_y, a_blank);
        else pass_cnt++;
      end
      ex = k % 800;
      ey = k / 800;
      eb = (ex < 640) && (ey < 480);
      px = (k - 1) % 800;
      eh = !((px >= 656) && (px <= 751));
      if (a_x !== 10'(ex) || a_y !== 10'(ey)) begin
        coord_err++;
        if (first_bad < 0) first_bad = k;
      end
      if (a_blank !== eb) blank_err++;
      if (a_hs !== eh) hs_err++;
      if (a_vs !== 1'b1 || a_fs !== 1'b0 || a_vbs !== 1'b0 || a_fc !== 16'd0) misc_err++;
      if (ey == 1 && a_blank === 1'b1) blank_line1++;
      if (k <= 800 && a_hs === 1'b0) begin
        hs_low_line0++;
        if (hs_first < 0) hs_first = k;
      end
`ifdef VGA_TIMING_TEST_PATTERN_EN
      if (k == 1 || px >= 640) etp = 12'h000;
      else etp = bars[px / 80];
      if (a_tp !== etp) tp_err++;
`endif
    end
    chk_cnt++;
    if (coord_err !== 0) $display("FAIL line_counters: %0d bad cycles (first at cycle %0d), want 0", coord_err, first_bad);
    else pass_cnt++;
    chk_cnt++;
    if (blank_err !== 0) $display("FAIL line_blank: %0d bad cycles, want 0", blank_err);
    else pass_cnt++;
    chk_cnt++;
    if (blank_line1 !== 640) $display("FAIL blank_width: got %0d visible cycles on line 1, want 640", blank_line1);
    else pass_cnt++;
    chk_cnt++;
    if (hs_err !== 0) $display("FAIL hs_shape: %0d bad cycles, want 0", hs_err);
    else pass_cnt++;
    chk_cnt++;
    if (hs_low_line0 !== 96 || hs_first !== 657)
      $display("FAIL hs_pulse: width=%0d first_cycle=%0d, want 96 and 657", hs_low_line0, hs_first);
    else pass_cnt++;
    chk_cnt++;
    if (misc_err !== 0) $display("FAIL line_vs_strobes: %0d bad cycles of vs/frame_start/vblank_start/frame_count, want 0", misc_err);
    else pass_cnt++;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    chk_cnt++;
    if (tp_err !== 0) $display("FAIL test_pattern: %0d bad cycles, want 0", tp_err);
    else pass_cnt++;
`endif
  endtask

  // Reset asserted while hsync is active, held 3 cycles, then released.
  task automatic test_mid_frame_reset();
    int hold_err, first_k;
    logic [9:0] first_x, first_y;
    hold_err = 0; first_k = -1; first_x = '0; first_y = '0;
    repeat (600) @(negedge vga_clk);  // cycle 2300: (700,2), inside hsync
    chk_cnt++;
    if ({a_x, a_y, a_hs} !== {10'd700, 10'd2, 1'b0})
      $display("FAIL pre_reset_pos: x=%0d y=%0d hs=%b, want 700 2 0", a_x, a_y, a_hs);
    else pass_cnt++;
    rst_a = 1'b1;
    #1;
    chk_cnt++;
    if ({a_x, a_y, a_blank, a_hs, a_vs, a_fc} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 16'd0})
      $display("FAIL async_reset: x=%0d y=%0d blank=%b hs=%b vs=%b fc=%0d, want 0 0 0 1 1 0",
               a_x, a_y, a_blank, a_hs, a_vs, a_fc);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge vga_clk);
      if ({a_x, a_y, a_blank, a_hs, a_vs, a_fs, a_vbs} !==
          {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) hold_err++;
    end
    chk_cnt++;
    if (hold_err !== 0) $display("FAIL reset_hold: %0d bad cycles while reset held, want 0", hold_err);
    else pass_cnt++;
    rst_a = 1'b0;
    for (int k = 1; k <= 800 && first_k < 0; k++) begin
      @(negedge vga_clk);
      if (a_hs !== 1'b1) begin
        first_k = k;
        first_x = a_x;
        first_y = a_y;
      end
    end
    chk_cnt++;
    if (first_k !== 657 || first_x !== 10'd657 || first_y !== 10'd0)
      $display("FAIL post_reset_hs: first hs change at cycle %0d (x=%0d y=%0d), want cycle 657 x=657 y=0",
               first_k, first_x, first_y);
    else pass_cnt++;
  endtask

  // Small raster (16x10, 160 cycles/frame): 17 frames of counters, syncs,
  // strobes and the 4-bit frame counter wrap.
  task automatic test_frames();
    int coord_err, blank_err, sync_err, strobe_err, fc_err;
    int fs_pulses, vbs_pulses, first_bad;
    int ex, ey, sx, sy;
    logic eb, ehs, evs, efs, evb;
    logic [3:0] efc;
    coord_err = 0; blank_err = 0; sync_err = 0; strobe_err = 0; fc_err = 0;
    fs_pulses = 0; vbs_pulses = 0; first_bad = -1;
    rst_b = 1'b0;
    for (int k = 1; k <= 2725; k++) begin
      @(negedge vga_clk);
      ex  = k % 16;
      ey  = (k / 16) % 10;
      eb  = (ex < 8) && (ey < 6);
      sx  = (k - 2) % 16;
      sy  = ((k - 2) / 16) % 10;
      ehs = (k >= 2) && (sx >= 10) && (sx <= 12);
      evs = (k >= 2) && (sy >= 7) && (sy <= 8);
      efs = (k % 160) == 0;
      evb = (k % 160) == 96;
      efc = 4'((k / 160) % 16);
      if (b_x !== 10'(ex) || b_y !== 10'(ey)) begin
        coord_err++;
        if (first_bad < 0) first_bad = k;
      end
      if (b_blank !== eb) blank_err++;
      if (b_hs !== ehs || b_vs !== evs) sync_err++;
      if (b_fs !== efs || b_vbs !== evb) strobe_err++;
      if (b_fc !== efc) fc_err++;
      if (b_fs === 1'b1) fs_pulses++;
      if (b_vbs === 1'b1) vbs_pulses++;
      if (k == 2559) begin
        chk_cnt++;
        if ({b_x, b_y, b_fc} !== {10'd15, 10'd9, 4'd15})
          $display("FAIL pre_wrap: x=%0d y=%0d fc=%0d, want 15 9 15", b_x, b_y, b_fc);
        else pass_cnt++;
      end
      if (k == 2560) begin
        chk_cnt++;
        if ({b_x, b_y, b_fc, b_fs} !== {10'd0, 10'd0, 4'd0, 1'b1})
          $display("FAIL fc_wrap: x=%0d y=%0d fc=%0d fs=%b, want 0 0 0 1", b_x, b_y, b_fc, b_fs);
        else pass_cnt++;
      end
      if (k == 2720) begin
        chk_cnt++;
        if (b_fc !== 4'd1) $display("FAIL fc_after_wrap: got %0d want 1", b_fc);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (coord_err !== 0) $display("FAIL frame_counters: %0d bad cycles (first at cycle %0d), want 0", coord_err, first_bad);
    else pass_cnt++;
    chk_cnt++;
    if (blank_err !== 0) $display("FAIL frame_blank: %0d bad cycles, want 0", blank_err);
    else pass_cnt++;
    chk_cnt++;
    if (sync_err !== 0) $display("FAIL frame_sync: %0d bad cycles of hs/vs, want 0", sync_err);
    else pass_cnt++;
    chk_cnt++;
    if (strobe_err !== 0) $display("FAIL frame_strobes: %0d bad cycles of frame_start/vblank_start, want 0", strobe_err);
    else pass_cnt++;
    chk_cnt++;
    if (fs_pulses !== 17 || vbs_pulses !== 17)
      $display("FAIL strobe_counts: frame_start=%0d vblank_start=%0d, want 17 and 17", fs_pulses, vbs_pulses);
    else pass_cnt++;
    chk_cnt++;
    if (fc_err !== 0) $display("FAIL frame_count_seq: %0d bad cycles, want 0", fc_err);
    else pass_cnt++;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    test_reset();
    test_line_timing();
    test_mid_frame_reset();
    test_frames();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule
